reg_write_arbiter: RTL and testbench



---
 rtl/reg_write_arbiter_pkg.sv | 19 +
 rtl/reg_write_arbiter_if.sv | 32 +++
 rtl/reg_write_arbiter_rr_picker.sv | 36 +++
 rtl/reg_write_arbiter.sv | 117 +++++++++++
 tb/tb_reg_write_arbiter.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/reg_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reg_write_arbiter_pkg
//  Description : Shared types and default sizes for the register write arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package reg_write_arbiter_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : reg_write_arbiter_pkg
`default_nettype wire

// File: rtl/reg_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_write_arbiter_if
//  Description : Requester-side request/data bundle and register write port.
//  Revision    : 1.0 - initial release
// ============================================================================
interface reg_write_arbiter_if
    import reg_write_arbiter_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       grant;
    logic                   ack;
    logic                   busy;
    logic [WIDTH-1:0]       reg_data;
    logic                   reg_enable;

    modport master (
        output req, req_data,
        input  grant, ack, busy, reg_data, reg_enable
    );

    modport slave (
        input  req, req_data,
        output grant, ack, busy, reg_data, reg_enable
    );

endinterface : reg_write_arbiter_if
`default_nettype wire

// File: rtl/reg_write_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_picker
//  Description : Combinational round-robin pick: first set req at or after ptr.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  wire logic [N_REQ-1:0] req,
    input  wire logic [PTR_W-1:0] ptr,
    output logic      [PTR_W-1:0] winner,
    output logic      [N_REQ-1:0] onehot,
    output logic                  any
);

    logic [PTR_W-1:0] w_idx;

    // Scan from the farthest offset down so the closest-to-ptr match wins.
    always_comb begin
        winner = '0;
        onehot = '0;
        w_idx  = '0;
        any    = |req;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_idx = PTR_W'((int'(ptr) + i) % N_REQ);
            if (req[w_idx]) begin
                winner = w_idx;
            end
        end
        onehot[winner] = any;
    end

endmodule : rr_picker
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : reg_write_arbiter
//  Description : Round-robin arbiter issuing one-cycle writes to a shared register.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int WIDTH = DEF_WIDTH
) (
    input  wire logic         clk,
    input  wire logic         reset,
    reg_write_arbiter_if.slave bus
);

    localparam int PTR_W = $clog2(N_REQ);

    state_t           r_state,      w_state_nxt;
    logic [N_REQ-1:0] r_grant,      w_grant_nxt;
    logic             r_ack,        w_ack_nxt;
    logic             r_busy,       w_busy_nxt;
    logic [WIDTH-1:0] r_reg_data,   w_reg_data_nxt;
    logic             r_reg_enable, w_reg_enable_nxt;
    logic [PTR_W-1:0] r_ptr,        w_ptr_nxt;
    logic [PTR_W-1:0] r_winner,     w_winner_nxt;

    logic [PTR_W-1:0] w_pick;
    logic [N_REQ-1:0] w_pick_onehot;
    logic             w_pick_any;

    rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req    (bus.req),
        .ptr    (r_ptr),
        .winner (w_pick),
        .onehot (w_pick_onehot),
        .any    (w_pick_any)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_ack        <= 1'b0;
            r_busy       <= 1'b0;
            r_reg_data   <= '0;
            r_reg_enable <= 1'b0;
            r_ptr        <= '0;
            r_winner     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_grant      <= w_grant_nxt;
            r_ack        <= w_ack_nxt;
            r_busy       <= w_busy_nxt;
            r_reg_data   <= w_reg_data_nxt;
            r_reg_enable <= w_reg_enable_nxt;
            r_ptr        <= w_ptr_nxt;
            r_winner     <= w_winner_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_ack_nxt        = 1'b0;
        w_busy_nxt       = r_busy;
        w_reg_data_nxt   = r_reg_data;
        w_reg_enable_nxt = 1'b0;
        w_ptr_nxt        = r_ptr;
        w_winner_nxt     = r_winner;

        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    // Data is captured only here; later req_data changes are ignored.
                    w_grant_nxt      = w_pick_onehot;
                    w_reg_data_nxt   = bus.req_data[int'(w_pick) * WIDTH +: WIDTH];
                    w_reg_enable_nxt = 1'b1;
                    w_busy_nxt       = 1'b1;
                    w_winner_nxt     = w_pick;
                    w_state_nxt      = WRITE;
                end else begin
                    w_grant_nxt = '0;
                    w_busy_nxt  = 1'b0;
                end
            end
            WRITE: begin
                w_ack_nxt   = 1'b1;
                w_busy_nxt  = 1'b1;
                w_state_nxt = DONE;
            end
            DONE: begin
                w_grant_nxt = '0;
                w_busy_nxt  = 1'b0;
                w_ptr_nxt   = (r_winner == PTR_W'(N_REQ - 1)) ? '0 : r_winner + PTR_W'(1);
                w_state_nxt = IDLE;
            end
            default: begin
                w_grant_nxt = '0;
                w_busy_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.grant      = r_grant;
    assign bus.ack        = r_ack;
    assign bus.busy       = r_busy;
    assign bus.reg_data   = r_reg_data;
    assign bus.reg_enable = r_reg_enable;

endmodule : reg_write_arbiter
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_write_arbiter
//  Description : Directed and random checks of reg_write_arbiter against a transaction model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_write_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic reset;

    reg_write_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

    reg_write_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Transaction model: age is cycles since grant (-1 when no transaction).
    int           m_ptr, m_age, m_winner;
    logic [N-1:0] m_grant;
    logic         m_ack, m_busy, m_en;
    logic [W-1:0] m_data;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        int w;
        logic [N*W-1:0] d;
        d = bus.req_data;
        if (!reset) begin
            m_grant = '0; m_ack = 0; m_busy = 0; m_en = 0; m_data = '0;
            m_ptr = 0; m_age = -1;
        end else if (m_age < 0) begin
            w = pick(bus.req, m_ptr);
            if (w >= 0) begin
                m_winner = w;
                m_grant  = N'(1) << w;
                m_data   = d[w*W +: W];
                m_en     = 1; m_busy = 1; m_ack = 0;
                m_age    = 0;
            end else begin
                m_grant = '0; m_en = 0; m_ack = 0; m_busy = 0;
            end
        end else if (m_age == 0) begin
            m_en = 0; m_ack = 1; m_age = 1;
        end else begin
            m_ack = 0; m_grant = '0; m_busy = 0;
            m_ptr = (m_winner + 1) % N;
            m_age = -1;
        end
        @(posedge clk);
        #1;
        chk("grant",      32'(bus.grant),      32'(m_grant));
        chk("ack",        32'(bus.ack),        32'(m_ack));
        chk("busy",       32'(bus.busy),       32'(m_busy));
        chk("reg_enable", 32'(bus.reg_enable), 32'(m_en));
        chk("reg_data",   32'(bus.reg_data),   32'(m_data));
        chk("grant_onehot0", 32'($countones(bus.grant) <= 1), 32'(1));
    endtask

    task automatic set_data(input int idx, input logic [W-1:0] v);
        logic [N*W-1:0] d;
        d = bus.req_data;
        d[idx*W +: W] = v;
        bus.req_data = d;
    endtask

    initial begin
        m_ptr = 0; m_age = -1; m_winner = 0;
        m_grant = '0; m_ack = 0; m_busy = 0; m_en = 0; m_data = '0;

        // Reset held with all requesters active
        reset = 1'b0;
        bus.req = 4'b1111;
        bus.req_data = '0;
        step();
        step();
        chk("rst_grant", 32'(bus.grant), 32'h0);
        chk("rst_busy",  32'(bus.busy),  32'h0);
        reset = 1'b1;
        step();
        chk("first_grant", 32'(bus.grant), 32'b0001);
        bus.req = '0;
        step(); step(); step();

        // Single request
        bus.req = 4'b0100;
        set_data(2, 8'hA5);
        step();
        chk("single_grant", 32'(bus.grant),    32'b0100);
        chk("single_data",  32'(bus.reg_data), 32'hA5);
        chk("single_en",    32'(bus.reg_enable), 32'h1);
        bus.req = '0;
        step();
        chk("single_ack", 32'(bus.ack), 32'h1);
        step();
        chk("single_idle", 32'({bus.grant, bus.ack, bus.busy}), 32'h0);

        // Fairness under continuous load (ptr now at 3)
        bus.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("fair_grant", 32'(bus.grant), 32'(1 << ((3 + k) % N)));
            step(); step();
        end
        bus.req = '0;
        step();

        // Mid-transaction request drop and data change
        bus.req = 4'b0010;
        set_data(1, 8'h3C);
        step();
        chk("mid_grant", 32'(bus.grant), 32'b0010);
        bus.req = '0;
        set_data(1, 8'hFF);
        step();
        chk("mid_data_hold", 32'(bus.reg_data), 32'h3C);
        chk("mid_ack",       32'(bus.ack),      32'h1);
        step();
        step();
        chk("mid_no_regrant", 32'(bus.grant), 32'h0);

        // Reset during WRITE, then wrap-around ordering
        bus.req = 4'b0100;
        step();
        reset = 1'b0;
        step();
        chk("midrst_all", 32'({bus.grant, bus.ack, bus.busy, bus.reg_enable}), 32'h0);
        chk("midrst_data", 32'(bus.reg_data), 32'h0);
        reset = 1'b1;
        bus.req = 4'b1001;
        step();
        chk("midrst_req0", 32'(bus.grant), 32'b0001);
        step(); step(); step();
        chk("rr_req3", 32'(bus.grant), 32'b1000);
        step(); step(); step();
        chk("wrap_req0", 32'(bus.grant), 32'b0001);
        bus.req = '0;
        step(); step(); step();

        // Random traffic with occasional resets
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 59) != 0);
            bus.req = ($urandom_range(0, 9) < 4) ? '0 : N'($urandom_range(0, (1 << N) - 1));
            bus.req_data = {$urandom()};
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_reg_write_arbiter
`default_nettype wire
